// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop synchroniser, mid-bit sampling,
// one-entry valid/ready holding register, framing/overrun pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clkin,
   input  logic                 reset_in,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 frame_err_out,
   output logic                 overrun_out,
   output logic                 busy_out
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int IW   = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, BREAK
   } state_t;

   state_t st, nxt;

   logic                 rx_meta, rx_s;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] sh;
   logic                 pend;
   logic                 cnt_clr, smp, done, ferr;

   always_ff @(posedge clkin) begin
      if (reset_in) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clkin) begin
      if (reset_in) st <= IDLE;
      else          st <= nxt;
   end

   always_comb begin
      nxt     = st;
      cnt_clr = 1'b0;
      smp     = 1'b0;
      done    = 1'b0;
      ferr    = 1'b0;
      unique case (st)
         IDLE: begin
            cnt_clr = 1'b1;
            if (!rx_s) nxt = START;
         end
         START: begin
            if (cnt == HALF_END) nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (cnt == BIT_END) begin
               smp     = 1'b1;
               cnt_clr = 1'b1;
               if (idx == LAST_BIT) nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == BIT_END) begin
               if (rx_s) begin
                  done = 1'b1;
                  nxt  = IDLE;
               end else begin
                  ferr = 1'b1;
                  nxt  = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_clr = 1'b1;
            if (rx_s) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clkin) begin
      if (reset_in) begin
         cnt <= '0;
         idx <= '0;
         sh  <= '0;
      end else begin
         if (nxt != st || cnt_clr) cnt <= '0;
         else                      cnt <= cnt + 1'b1;
         if (st == START) idx <= '0;
         else if (smp)    idx <= idx + 1'b1;
         if (smp) sh <= {rx_s, sh[DATA_BITS-1:1]};
      end
   end

   // Delivery is resolved one cycle after the stop sample.
   always_ff @(posedge clkin) begin
      if (reset_in) begin
         pend          <= 1'b0;
         data_out      <= '0;
         valid_out     <= 1'b0;
         frame_err_out <= 1'b0;
         overrun_out   <= 1'b0;
      end else begin
         pend          <= done;
         frame_err_out <= ferr;
         overrun_out   <= 1'b0;
         if (pend) begin
            if (!valid_out || ready_in) begin
               data_out  <= sh;
               valid_out <= 1'b1;
            end else begin
               overrun_out <= 1'b1;
            end
         end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
         end
      end
   end

   assign busy_out = (st != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames checked against a byte-level
// model of the receiver (expected bytes, error and overrun counts).
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clkin = 1'b0;
   logic       reset_in = 1'b1;
   logic       rx_in = 1'b1;
   logic       ready_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out, frame_err_out, overrun_out, busy_out;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clkin(clkin),
      .reset_in(reset_in),
      .rx_in(rx_in),
      .data_out(data_out),
      .valid_out(valid_out),
      .ready_in(ready_in),
      .frame_err_out(frame_err_out),
      .overrun_out(overrun_out),
      .busy_out(busy_out)
   );

   always #5 clkin = ~clkin;

   int cyc = 0;
   always @(posedge clkin) cyc <= cyc + 1;

   // Passive monitor: event counters and a log of accepted bytes.
   int fe_n = 0, ov_n = 0, busy_n = 0, vrise = 0, vhigh = 0;
   int last_rise = 0, rx_n = 0;
   logic [7:0] rx_log [0:255];
   logic pv = 1'b0;
   always @(negedge clkin) begin
      if (valid_out) vhigh++;
      if (valid_out && !pv) begin
         vrise++;
         last_rise = cyc;
      end
      pv = valid_out;
      if (frame_err_out) fe_n++;
      if (overrun_out) ov_n++;
      if (busy_out) busy_n++;
      if (valid_out && ready_in) begin
         rx_log[rx_n[7:0]] = data_out;
         rx_n++;
      end
   end

   int errors = 0, checks = 0;
   int fe0, ov0, bz0, vr0, vh0, rx0, fall;

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      fe0 = fe_n; ov0 = ov_n; bz0 = busy_n;
      vr0 = vrise; vh0 = vhigh; rx0 = rx_n;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      fall = cyc;
      for (int i = 0; i < 10; i++) begin
         rx_in = bits[i];
         repeat (CPB) tick();
      end
   endtask

   logic [7:0] exp_q [$];
   logic [7:0] rb;
   logic       bad;
   int         exp_fe, gap;

   initial begin
      repeat (3) tick();
      reset_in = 1'b0;
      tick();
      check("rst_data", 32'(data_out), 32'h0);
      check("rst_valid", 32'(valid_out), 32'h0);
      check("rst_ferr", 32'(frame_err_out), 32'h0);
      check("rst_ovr", 32'(overrun_out), 32'h0);
      check("rst_busy", 32'(busy_out), 32'h0);

      // single frame, consumer always ready
      ready_in = 1'b1;
      snap();
      send_frame(8'hA5, 1'b1);
      repeat (4) tick();
      check("a5_latency", 32'(last_rise - fall), 32'd156);
      check("a5_vhigh", 32'(vhigh - vh0), 32'd1);
      check("a5_count", 32'(rx_n - rx0), 32'd1);
      check("a5_data", 32'(rx_log[rx0[7:0]]), 32'hA5);
      check("a5_ferr", 32'(fe_n - fe0), 32'd0);
      check("a5_ovr", 32'(ov_n - ov0), 32'd0);

      // overrun: two frames, consumer stalled
      ready_in = 1'b0;
      snap();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (4) tick();
      check("ovr_data", 32'(data_out), 32'h00);
      check("ovr_valid", 32'(valid_out), 32'h1);
      check("ovr_pulses", 32'(ov_n - ov0), 32'd1);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      tick();
      check("ovr_drained", 32'(valid_out), 32'h0);
      check("ovr_taken", 32'(rx_n - rx0), 32'd1);
      check("ovr_byte", 32'(rx_log[rx0[7:0]]), 32'h00);

      // short glitch on the line
      repeat (10) tick();
      snap();
      rx_in = 1'b0;
      repeat (4) tick();
      rx_in = 1'b1;
      repeat (20) tick();
      check("gl_busy", 32'(busy_n - bz0), 32'd8);
      check("gl_valid", 32'(vrise - vr0), 32'd0);
      check("gl_ferr", 32'(fe_n - fe0), 32'd0);
      check("gl_idle", 32'(busy_out), 32'h0);

      // bad stop then break, then a clean frame
      ready_in = 1'b1;
      snap();
      send_frame(8'h3C, 1'b0);
      repeat (100) tick();
      rx_in = 1'b1;
      repeat (10) tick();
      check("brk_ferr", 32'(fe_n - fe0), 32'd1);
      check("brk_valid", 32'(vrise - vr0), 32'd0);
      send_frame(8'h81, 1'b1);
      repeat (4) tick();
      check("brk_count", 32'(rx_n - rx0), 32'd1);
      check("brk_data", 32'(rx_log[rx0[7:0]]), 32'h81);
      check("brk_ferr2", 32'(fe_n - fe0), 32'd1);

      // ready on the exact cycle the second byte completes
      ready_in = 1'b0;
      repeat (5) tick();
      snap();
      send_frame(8'h12, 1'b1);
      fork
         send_frame(8'h34, 1'b1);
         begin
            repeat (155) tick();
            ready_in = 1'b1;
            tick();
            ready_in = 1'b0;
         end
      join
      tick();
      check("hs_data", 32'(data_out), 32'h34);
      check("hs_valid", 32'(valid_out), 32'h1);
      check("hs_ovr", 32'(ov_n - ov0), 32'd0);
      check("hs_count", 32'(rx_n - rx0), 32'd1);
      check("hs_first", 32'(rx_log[rx0[7:0]]), 32'h12);

      // reset mid-frame (held byte 0x34 also discarded)
      rx_in = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 3; i++) begin
         rx_in = 1'(i == 1);
         repeat (CPB) tick();
      end
      repeat (4) tick();
      reset_in = 1'b1;
      rx_in = 1'b1;
      tick();
      check("mr_data", 32'(data_out), 32'h0);
      check("mr_valid", 32'(valid_out), 32'h0);
      check("mr_busy", 32'(busy_out), 32'h0);
      check("mr_ferr", 32'(frame_err_out), 32'h0);
      check("mr_ovr", 32'(overrun_out), 32'h0);
      reset_in = 1'b0;
      ready_in = 1'b1;
      repeat (20) tick();
      snap();
      send_frame(8'h5A, 1'b1);
      repeat (4) tick();
      check("mr_count", 32'(rx_n - rx0), 32'd1);
      check("mr_byte", 32'(rx_log[rx0[7:0]]), 32'h5A);
      check("mr_errs", 32'((fe_n - fe0) + (ov_n - ov0)), 32'd0);

      // randomized frames against the byte-level model
      snap();
      exp_fe = 0;
      for (int f = 0; f < 12; f++) begin
         rb  = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         send_frame(rb, !bad);
         if (bad) exp_fe++;
         else exp_q.push_back(rb);
         gap = bad ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 6));
         rx_in = 1'b1;
         repeat (gap) tick();
      end
      repeat (10) tick();
      check("rnd_ferr", 32'(fe_n - fe0), 32'(exp_fe));
      check("rnd_ovr", 32'(ov_n - ov0), 32'd0);
      check("rnd_count", 32'(rx_n - rx0), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         check("rnd_byte", 32'(rx_log[8'(rx0 + k)]), 32'(exp_q[k]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
